// File: rtl/op_lut_hdr_writer.sv
// Buffers packets until their forwarding decision arrives, then rewrites the IOQ
// header dst-port field and forwards the packet, or discards it on a drop decision.
module op_lut_hdr_writer #(
    parameter int unsigned DATA_WIDTH         = 64,
    parameter int unsigned CTRL_WIDTH         = DATA_WIDTH / 8,
    parameter int unsigned NUM_QUEUES         = 8,
    parameter int unsigned IO_QUEUE_STAGE_NUM = 32'hFF,
    parameter int unsigned DST_PORT_POS       = 48,
    parameter int unsigned BUF_DEPTH_BITS     = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  in_wr,
    output logic                  in_rdy,
    input  logic [NUM_QUEUES-1:0] dst_port,
    input  logic                  drop,
    input  logic                  decision_vld,
    output logic                  rd_decision,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic                  out_wr,
    input  logic                  out_rdy,
    output logic                  pkt_dropped
);

    localparam int unsigned DEPTH  = 1 << BUF_DEPTH_BITS;
    localparam int unsigned WORD_W = CTRL_WIDTH + DATA_WIDTH;
    localparam int unsigned CNT_W  = BUF_DEPTH_BITS + 1;

    localparam logic [CTRL_WIDTH-1:0]     IOQ_CTRL   = CTRL_WIDTH'(IO_QUEUE_STAGE_NUM);
    localparam logic [CNT_W-1:0]          NF_LEVEL   = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]          FULL_LEVEL = CNT_W'(DEPTH);
    localparam logic [BUF_DEPTH_BITS-1:0] PTR_ONE    = BUF_DEPTH_BITS'(1);

    typedef enum logic [1:0] {
        WAIT_DEC = 2'd0,
        SEND     = 2'd1,
        DROP     = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WORD_W-1:0]         mem [DEPTH];
    logic [BUF_DEPTH_BITS-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0]          count, count_next;

    logic [WORD_W-1:0]     head_word;
    logic [CTRL_WIDTH-1:0] head_ctrl;
    logic [DATA_WIDTH-1:0] head_data;
    logic [DATA_WIDTH-1:0] mod_data;

    logic                  fifo_empty, fifo_full, wr_en;
    logic                  in_body, hdr_done, head_eop, hdr_hit;
    logic [NUM_QUEUES-1:0] dst_q;

    logic rd_en_c, dec_take_c, send_c, drop_done_c;

    // Fallthrough buffer: head word is visible combinationally at rd_ptr
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_LEVEL);
    assign wr_en      = in_wr && !fifo_full;
    assign head_word  = mem[rd_ptr];
    assign head_ctrl  = head_word[WORD_W-1:DATA_WIDTH];
    assign head_data  = head_word[DATA_WIDTH-1:0];

    // EOP is the first non-zero ctrl word after the body has started
    assign head_eop = in_body && (head_ctrl != '0);
    assign hdr_hit  = (head_ctrl == IOQ_CTRL) && !in_body && !hdr_done;

    always_comb begin
        mod_data = head_data;
        if (hdr_hit) begin
            mod_data[DST_PORT_POS +: 16] = 16'(dst_q);
        end
    end

    always_comb begin
        count_next = count + CNT_W'(wr_en) - CNT_W'(rd_en_c);
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {in_ctrl, in_data};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= WAIT_DEC;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        rd_en_c     = 1'b0;
        dec_take_c  = 1'b0;
        send_c      = 1'b0;
        drop_done_c = 1'b0;
        case (state)
            WAIT_DEC: begin
                if (!fifo_empty && decision_vld) begin
                    dec_take_c = 1'b1;
                    state_next = drop ? DROP : SEND;
                end
            end
            SEND: begin
                if (!fifo_empty && out_rdy) begin
                    rd_en_c = 1'b1;
                    send_c  = 1'b1;
                    if (head_eop) begin
                        state_next = WAIT_DEC;
                    end
                end
            end
            DROP: begin
                if (!fifo_empty) begin
                    rd_en_c = 1'b1;
                    if (head_eop) begin
                        drop_done_c = 1'b1;
                        state_next  = WAIT_DEC;
                    end
                end
            end
            default: state_next = WAIT_DEC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            in_rdy      <= 1'b1;
            in_body     <= 1'b0;
            hdr_done    <= 1'b0;
            dst_q       <= '0;
            rd_decision <= 1'b0;
            pkt_dropped <= 1'b0;
            out_wr      <= 1'b0;
            out_data    <= '0;
            out_ctrl    <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_en_c) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count       <= count_next;
            in_rdy      <= (count_next < NF_LEVEL);
            rd_decision <= dec_take_c;
            pkt_dropped <= drop_done_c;
            out_wr      <= send_c;
            if (send_c) begin
                out_data <= mod_data;
                out_ctrl <= head_ctrl;
            end
            if (dec_take_c) begin
                dst_q    <= dst_port;
                hdr_done <= 1'b0;
            end else if (send_c && hdr_hit) begin
                hdr_done <= 1'b1;
            end
            // Body flag tracks delimiting of popped words in both SEND and DROP
            if (rd_en_c) begin
                if (head_ctrl == '0) begin
                    in_body <= 1'b1;
                end else if (in_body) begin
                    in_body <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_op_lut_hdr_writer.sv
// Scoreboard bench for op_lut_hdr_writer: expected words are queued as packets are
// written and compared as the DUT emits them.
module tb_op_lut_hdr_writer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] in_data = '0;
    logic [7:0]  in_ctrl = '0;
    logic        in_wr = 1'b0;
    logic        in_rdy;
    logic [7:0]  dst_port = '0;
    logic        drop = 1'b0;
    logic        decision_vld = 1'b0;
    logic        rd_decision;
    logic [63:0] out_data;
    logic [7:0]  out_ctrl;
    logic        out_wr;
    logic        out_rdy = 1'b1;
    logic        pkt_dropped;

    logic [71:0] exp_q[$];
    logic [8:0]  dec_q[$];
    int checks = 0, errors = 0;
    int rd_cnt = 0, drop_cnt = 0, out_cnt = 0, exp_drops = 0, dec_pushed = 0;
    int cyc = 0;
    bit prev_rdy = 1'b1;

    op_lut_hdr_writer dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
        .dst_port(dst_port), .drop(drop), .decision_vld(decision_vld),
        .rd_decision(rd_decision),
        .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
        .pkt_dropped(pkt_dropped)
    );

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Decision FIFO model plus output scoreboard, sampled on the falling edge
    initial forever begin
        logic [71:0] w;
        @(negedge clk);
        if (reset) begin
            prev_rdy = 1'b1;
        end else begin
            if (rd_decision) begin
                rd_cnt++;
                checks++;
                if (dec_q.size() == 0) begin
                    errors++;
                    $display("FAIL dec_pop: rd_decision=1 got, no decision pending (required rd_decision=0)");
                end else begin
                    void'(dec_q.pop_front());
                end
            end
            if (pkt_dropped) drop_cnt++;
            if (!prev_rdy) begin
                checks++;
                if (out_wr !== 1'b0) begin
                    errors++;
                    $display("FAIL out_wr_after_nrdy: got %b required 0", out_wr);
                end
            end
            if (out_wr) begin
                out_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word: got %h_%h, nothing expected", out_ctrl, out_data);
                end else begin
                    w = exp_q.pop_front();
                    if ({out_ctrl, out_data} !== w) begin
                        errors++;
                        $display("FAIL out_word: got %h_%h required %h_%h",
                                 out_ctrl, out_data, w[71:64], w[63:0]);
                    end
                end
            end
            prev_rdy = out_rdy;
        end
        decision_vld = (dec_q.size() != 0);
        if (dec_q.size() != 0) {drop, dst_port} = dec_q[0];
    end

    task automatic push_dec(input logic [7:0] dst, input logic drp);
        dec_q.push_back({drp, dst});
        dec_pushed++;
    endtask

    // Builds header + nbody data words + EOP, queues expected output, writes it in
    task automatic write_pkt(input int nbody, input logic [7:0] dst, input logic drp,
                             input logic [15:0] hdr_top);
        logic [71:0] words[$];
        int n;
        words.push_back({8'hFF, hdr_top, 32'($urandom), 16'(nbody + 2)});
        for (int i = 0; i < nbody; i++) words.push_back({8'h00, 32'($urandom), 32'($urandom)});
        words.push_back({8'h80, 32'($urandom), 32'($urandom)});
        if (drp) begin
            exp_drops++;
        end else begin
            for (int i = 0; i < words.size(); i++) begin
                if (i == 0) exp_q.push_back({words[i][71:64], 8'h00, dst, words[i][47:0]});
                else        exp_q.push_back(words[i]);
            end
        end
        for (int i = 0; i < words.size(); i++) begin
            n = 0;
            while (!in_rdy && n < 2000) begin @(posedge clk); #1; n++; end
            if (!in_rdy) begin
                checks++;
                errors++;
                $display("FAIL in_rdy_wait: got in_rdy=0 for 2000 cycles required 1");
            end
            in_wr = 1'b1;
            {in_ctrl, in_data} = words[i];
            @(posedge clk); #1;
        end
        in_wr = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || dec_q.size() != 0) && n < 3000) begin
            @(posedge clk); #1; n++;
        end
        repeat (4) begin @(posedge clk); #1; end
        checks++;
        if (exp_q.size() != 0 || dec_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d words %0d decisions pending required 0 0",
                     exp_q.size(), dec_q.size());
        end
    endtask

    task automatic test_reset();
        @(negedge clk); #1;
        checks++;
        if ({out_wr, rd_decision, pkt_dropped, out_data, out_ctrl, in_rdy} !== {3'b000, 72'h0, 1'b1}) begin
            errors++;
            $display("FAIL reset_vals: got wr=%b rd=%b pd=%b data=%h ctrl=%h rdy=%b required 0 0 0 0 0 1",
                     out_wr, rd_decision, pkt_dropped, out_data, out_ctrl, in_rdy);
        end
    endtask

    task automatic test_single();
        int b_rd = rd_cnt, b_out = out_cnt;
        push_dec(8'h04, 1'b0);
        write_pkt(2, 8'h04, 1'b0, 16'h0000);
        drain();
        checks++;
        if (rd_cnt - b_rd != 1) begin
            errors++;
            $display("FAIL single_rd_dec: got %0d pulses required 1", rd_cnt - b_rd);
        end
        checks++;
        if (out_cnt - b_out != 4) begin
            errors++;
            $display("FAIL single_words: got %0d required 4", out_cnt - b_out);
        end
    endtask

    task automatic test_drop();
        int b_drop = drop_cnt, b_out = out_cnt;
        push_dec(8'h04, 1'b1);
        write_pkt(2, 8'h04, 1'b1, 16'h0000);
        push_dec(8'h10, 1'b0);
        write_pkt(2, 8'h10, 1'b0, 16'h0000);
        drain();
        checks++;
        if (drop_cnt - b_drop != 1) begin
            errors++;
            $display("FAIL drop_pulse: got %0d required 1", drop_cnt - b_drop);
        end
        checks++;
        if (out_cnt - b_out != 4) begin
            errors++;
            $display("FAIL drop_words: got %0d required 4", out_cnt - b_out);
        end
    endtask

    task automatic test_late_decision();
        int b_rd = rd_cnt, b_out = out_cnt, t0, n;
        write_pkt(2, 8'h02, 1'b0, 16'h0000);
        repeat (5) begin @(posedge clk); #1; end
        checks++;
        if (rd_cnt != b_rd || out_cnt != b_out) begin
            errors++;
            $display("FAIL late_idle: got rd=%0d out=%0d required 0 0", rd_cnt - b_rd, out_cnt - b_out);
        end
        push_dec(8'h02, 1'b0);
        @(negedge clk); #1;
        t0 = cyc;
        n = 0;
        while (!out_wr && n < 20) begin @(negedge clk); #1; n++; end
        checks++;
        if (!out_wr || cyc - t0 != 2) begin
            errors++;
            $display("FAIL late_latency: got %0d cycles required 2", cyc - t0);
        end
        drain();
    endtask

    task automatic test_backpressure();
        logic [3:0] pat = 4'b1001;
        push_dec(8'h20, 1'b0);
        write_pkt(10, 8'h20, 1'b0, 16'hBEEF);
        for (int i = 0; i < 40; i++) begin
            out_rdy = pat[i % 4];
            @(posedge clk); #1;
        end
        out_rdy = 1'b1;
        drain();
    endtask

    task automatic test_back_to_back();
        push_dec(8'h00, 1'b0);
        push_dec(8'h01, 1'b0);
        push_dec(8'h08, 1'b1);
        write_pkt(1, 8'h00, 1'b0, 16'h1234);
        write_pkt(3, 8'h01, 1'b0, 16'h0000);
        write_pkt(2, 8'h08, 1'b1, 16'h0000);
        drain();
    endtask

    task automatic test_fill();
        int n = 0;
        out_rdy = 1'b0;
        push_dec(8'h80, 1'b0);
        write_pkt(253, 8'h80, 1'b0, 16'h0000);
        checks++;
        if (in_rdy !== 1'b0) begin
            errors++;
            $display("FAIL fill_nrdy: got in_rdy=%b required 0", in_rdy);
        end
        out_rdy = 1'b1;
        while (!in_rdy && n < 10) begin @(posedge clk); #1; n++; end
        checks++;
        if (in_rdy !== 1'b1) begin
            errors++;
            $display("FAIL fill_rdy_back: got in_rdy=%b required 1", in_rdy);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        int b_out, n = 0;
        out_rdy = 1'b0;
        write_pkt(6, 8'h40, 1'b0, 16'h0000);
        push_dec(8'h40, 1'b0);
        b_out = out_cnt;
        out_rdy = 1'b1;
        while (out_cnt - b_out < 2 && n < 50) begin @(negedge clk); #1; n++; end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({out_wr, out_data, out_ctrl, in_rdy} !== {1'b0, 72'h0, 1'b1}) begin
            errors++;
            $display("FAIL reset_mid: got wr=%b data=%h ctrl=%h rdy=%b required 0 0 0 1",
                     out_wr, out_data, out_ctrl, in_rdy);
        end
        reset = 1'b0;
        exp_q.delete();
        dec_q.delete();
        repeat (3) begin @(posedge clk); #1; end
        push_dec(8'h40, 1'b0);
        write_pkt(3, 8'h40, 1'b0, 16'hFFFF);
        drain();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        test_single();
        test_drop();
        test_late_decision();
        test_backpressure();
        test_back_to_back();
        test_fill();
        test_reset_mid();
        checks++;
        if (drop_cnt != exp_drops) begin
            errors++;
            $display("FAIL drop_total: got %0d required %0d", drop_cnt, exp_drops);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/op_lut_hdr_writer.md
Name: op_lut_hdr_writer

Overview:
- Output-side counterpart of the output-port lookup header parser. Buffers each packet and waits for that packet's forwarding decision.
- Then rewrites the destination-port field of the IOQ module header (ctrl == IO_QUEUE_STAGE_NUM) and forwards the packet to the output queues. Packets with a drop decision are discarded.
- Sits at the tail of the output_port_lookup stage, between the lookup/process block and the output-queues interface.

Parameters:
- DATA_WIDTH, 64, datapath width.
- CTRL_WIDTH, DATA_WIDTH/8, ctrl width.
- NUM_QUEUES, 8, number of output queues (one-hot dst width).
- IO_QUEUE_STAGE_NUM, `IO_QUEUE_STAGE_NUM (0xFF), ctrl value marking the IOQ module header.
- DST_PORT_POS, `IOQ_DST_PORT_POS (48), LSB of the 16-bit dst-port field in the IOQ header.
- BUF_DEPTH_BITS, 8, log2 of the packet word buffer depth.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- in_data  in  DATA_WIDTH  upstream data word
- in_ctrl  in  CTRL_WIDTH  upstream ctrl
- in_wr  in  1  upstream word valid
- in_rdy  out  1  buffer can accept a word
- dst_port  in  NUM_QUEUES  one-hot output port for head packet
- drop  in  1  discard head packet
- decision_vld  in  1  dst_port/drop valid (head of decision FIFO)
- rd_decision  out  1  one-cycle pop of decision FIFO
- out_data  out  DATA_WIDTH  downstream data
- out_ctrl  out  CTRL_WIDTH  downstream ctrl
- out_wr  out  1  downstream word valid
- out_rdy  in  1  downstream may accept a word
- pkt_dropped  out  1  one-cycle pulse per discarded packet

Behaviour:
- Clocking and reset: reset is synchronous, active-high; clock is clk.
- Reset values: out_wr=0, rd_decision=0, pkt_dropped=0, out_data=0, out_ctrl=0, state=WAIT_DEC.
- Reset mid-packet flushes the buffer and the body flag; a partial packet is lost.
- Buffer: fallthrough FIFO of {ctrl,data}, depth 2^BUF_DEPTH_BITS.
  - in_rdy = !nearly_full, with nearly_full at depth-1.
  - in_wr while full is a protocol violation; the word is ignored.
  - A word written in cycle N is at the FIFO head in cycle N+1.
- Packet delimiting (output side):
  - Words with ctrl!=0 before the first ctrl==0 word are module headers.
  - The first ctrl==0 word sets in_body.
  - The next ctrl!=0 word with in_body=1 is EOP and clears in_body.
- State machine:
  - WAIT_DEC:
    - Waits for FIFO !empty && decision_vld.
    - Latches dst_port and drop, and asserts rd_decision for exactly that one cycle.
    - Goes to DROP if drop=1, otherwise to SEND.
    - A decision is never popped without a packet at the head.
  - SEND:
    - Each cycle with FIFO !empty && out_rdy, pops one word and registers it to the outputs with out_wr=1 the next cycle (1-cycle registered latency).
    - If the head word has ctrl==IO_QUEUE_STAGE_NUM, out_data[DST_PORT_POS+:16] = zero-extended latched dst_port; all other bits and words pass unmodified.
    - Only the first IOQ header of the packet is rewritten.
    - On popping EOP, goes to WAIT_DEC.
    - out_rdy low: no pop, and out_wr=0 next cycle.
    - FIFO empty mid-packet: stall, with no out_wr.
  - DROP:
    - Pops one word per cycle while !empty, independent of out_rdy, with out_wr=0.
    - On popping EOP, pulses pkt_dropped the next cycle and goes to WAIT_DEC.
- Back-to-back packets: WAIT_DEC lasts 1 cycle minimum, so there is one idle output cycle between packets.
- out_rdy follows the NetFPGA convention: it is sampled before asserting out_wr and guarantees room for at least one word.
- Widths:
  - dst_port wider than 16 bits is not supported.
  - When NUM_QUEUES<16, the upper bits of the field are written 0.
  - dst_port=0 with drop=0 passes through with field=0 (no special case).

Test Plan:
- Single 4-word packet (IOQ hdr {dst=0,len}, two data words with ctrl=0, EOP ctrl=0x80), decision dst=0x04 drop=0 -> four out_wr words; header bits[63:48]=0x0004, other bits and words unchanged; rd_decision pulses once.
- Same packet with drop=1 -> no out_wr; pkt_dropped pulses once after EOP pops; the following packet (dst=0x10) is forwarded with 0x0010.
- Packet arrives 5 cycles before decision_vld -> no out_wr and no rd_decision until decision_vld; the first output word appears 2 cycles after decision_vld.
- out_rdy toggled 1,0,0,1 during SEND -> no words lost or duplicated; out_wr=0 in cycles following out_rdy=0; order preserved.
- Fill the buffer to depth-1 with out_rdy=0 -> in_rdy deasserts; release out_rdy -> in_rdy reasserts and all words emerge in order.
- Assert reset mid-packet after 2 words sent -> outputs are 0 next cycle, the buffer is empty, and a fresh packet afterwards is rewritten correctly.
